// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: forwarding-select encoding and shadow stage entry.
package pipe_ctrl_pkg;

    // Widest register index the shadow entries can hold; narrower indices are zero-extended.
    localparam int unsigned RD_W_MAX = 8;

    typedef logic [RD_W_MAX-1:0] rd_t;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_WB      = 2'b01,
        FWD_MEM     = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic valid;
        rd_t  rd;
        logic regwrite;
        logic memread;
    } stage_t;

    // Register 0 is hardwired zero and never matches a producer.
    function automatic logic rd_match(rd_t src, rd_t dst);
        return (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/forward_hazard_unit_fwd_sel_cmp.sv
// One operand's forwarding comparator: next select plus load-use hit against the EX entry.
module fwd_sel_cmp
    import pipe_ctrl_pkg::*;
(
    input  rd_t      src,
    input  stage_t   ex,
    input  logic     mem_valid,
    input  rd_t      mem_rd,
    input  logic     mem_regwrite,
    output fwd_sel_e sel_next,
    output logic     load_hit
);

    // EX producer is the newest value, so it outranks the MEM producer.
    always_comb begin
        sel_next = FWD_REGFILE;
        if (ex.valid && ex.regwrite && rd_match(src, ex.rd)) begin
            sel_next = FWD_MEM;
        end else if (mem_valid && mem_regwrite && rd_match(src, mem_rd)) begin
            sel_next = FWD_WB;
        end
    end

    assign load_hit = ex.valid & ex.memread & ex.regwrite & rd_match(src, ex.rd);

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding-select and load-use hazard unit for the EX operand muxes.
// Define HAZARD_STATS_EN to add stall_cnt_o / fwd_cnt_o event counters.
module forward_hazard_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
`ifdef HAZARD_STATS_EN
    ,
    parameter int unsigned STAT_W     = 32
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    input  logic                  flush_i,
    output logic [1:0]            fwd_a_sel_o,
    output logic [1:0]            fwd_b_sel_o,
    output logic                  stall_o,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  idex_bubble_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0]     stall_cnt_o,
    output logic [STAT_W-1:0]     fwd_cnt_o
`endif
);

    // WB producers are covered by the write-before-read register file, so no WB entry is kept.
    stage_t   ex_q;
    logic     mem_valid_q;
    rd_t      mem_rd_q;
    logic     mem_regwrite_q;
    fwd_sel_e sel_a_q, sel_b_q;
    fwd_sel_e sel_a_next, sel_b_next;
    logic     hit_a, hit_b;
    logic     haz;

    fwd_sel_cmp u_cmp_a (
        .src          (rd_t'(id_rs_i)),
        .ex           (ex_q),
        .mem_valid    (mem_valid_q),
        .mem_rd       (mem_rd_q),
        .mem_regwrite (mem_regwrite_q),
        .sel_next     (sel_a_next),
        .load_hit     (hit_a)
    );

    fwd_sel_cmp u_cmp_b (
        .src          (rd_t'(id_rt_i)),
        .ex           (ex_q),
        .mem_valid    (mem_valid_q),
        .mem_rd       (mem_rd_q),
        .mem_regwrite (mem_regwrite_q),
        .sel_next     (sel_b_next),
        .load_hit     (hit_b)
    );

    assign haz           = id_valid_i & (hit_a | hit_b);
    assign stall_o       = haz & ~flush_i;
    assign pc_write_o    = ~stall_o;
    assign ifid_write_o  = ~stall_o;
    assign idex_bubble_o = stall_o | flush_i;
    assign fwd_a_sel_o   = sel_a_q;
    assign fwd_b_sel_o   = sel_b_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q           <= '0;
            mem_valid_q    <= 1'b0;
            mem_rd_q       <= '0;
            mem_regwrite_q <= 1'b0;
            sel_a_q        <= FWD_REGFILE;
            sel_b_q        <= FWD_REGFILE;
        end else begin
            mem_valid_q    <= ex_q.valid;
            mem_rd_q       <= ex_q.rd;
            mem_regwrite_q <= ex_q.regwrite;
            if (idex_bubble_o) begin
                ex_q.valid <= 1'b0;
                sel_a_q    <= FWD_REGFILE;
                sel_b_q    <= FWD_REGFILE;
            end else begin
                ex_q.valid    <= id_valid_i;
                ex_q.rd       <= rd_t'(id_rd_i);
                ex_q.regwrite <= id_regwrite_i;
                ex_q.memread  <= id_memread_i;
                sel_a_q       <= sel_a_next;
                sel_b_q       <= sel_b_next;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic fwd_inc;

    assign fwd_inc = ~idex_bubble_o &
                     ((sel_a_next != FWD_REGFILE) | (sel_b_next != FWD_REGFILE));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            fwd_cnt_o   <= '0;
        end else begin
            if (stall_o) stall_cnt_o <= stall_cnt_o + STAT_W'(1);
            if (fwd_inc) fwd_cnt_o   <= fwd_cnt_o + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench for forward_hazard_unit: directed pipeline scenarios plus random traffic.
module tb_forward_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_regwrite, id_memread, flush;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, pc_write, ifid_write, idex_bubble;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, fwd_cnt;
`endif

    always #5 clk = ~clk;

    forward_hazard_unit dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_rd_i       (id_rd),
        .id_regwrite_i (id_regwrite),
        .id_memread_i  (id_memread),
        .flush_i       (flush),
        .fwd_a_sel_o   (fwd_a_sel),
        .fwd_b_sel_o   (fwd_b_sel),
        .stall_o       (stall),
        .pc_write_o    (pc_write),
        .ifid_write_o  (ifid_write),
        .idex_bubble_o (idex_bubble)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt_o   (stall_cnt),
        .fwd_cnt_o     (fwd_cnt)
`endif
    );

    // Reference model: list of instructions issued into EX, newest last.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rw;
        bit       mr;
    } ins_t;

    ins_t        hist[$];
    bit          last_stall;
    int unsigned exp_stall_cnt, exp_fwd_cnt;
    int unsigned vectors, miscompares;

    bit       r_v, r_rw, r_mr, r_fl;
    bit [4:0] r_rs, r_rt, r_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ins_t back(int d);
        ins_t none = '{default: 0};
        if (hist.size() >= d) return hist[hist.size() - d];
        return none;
    endfunction

    function automatic bit produces(ins_t p, bit [4:0] src);
        return p.v && p.rw && (src != 0) && (p.rd == src);
    endfunction

    // Distance 1 = result in EX/MEM, distance 2 = result in MEM/WB.
    function automatic logic [1:0] exp_sel(bit [4:0] src);
        if (produces(back(1), src)) return 2'b10;
        if (produces(back(2), src)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic step(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                        input bit rw, input bit mr, input bit fl);
        bit         e_stall, e_bub;
        logic [1:0] esa, esb;
        ins_t       p1, cur;
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_regwrite = rw; id_memread = mr; flush = fl;
        p1 = back(1);
        e_stall = v && !fl && p1.v && p1.mr && p1.rw && (p1.rd != 0) &&
                  ((p1.rd == rs) || (p1.rd == rt));
        e_bub = e_stall || fl;
        #1;
        chk("stall", stall, e_stall);
        chk("pc_write", pc_write, !e_stall);
        chk("ifid_write", ifid_write, !e_stall);
        chk("idex_bubble", idex_bubble, e_bub);
        esa = e_bub ? 2'b00 : exp_sel(rs);
        esb = e_bub ? 2'b00 : exp_sel(rt);
        cur = e_bub ? '{default: 0} : '{v: v, rd: rd, rw: rw, mr: mr};
        @(posedge clk);
        hist.push_back(cur);
        if (hist.size() > 4) void'(hist.pop_front());
        if (e_stall) exp_stall_cnt++;
        if (esa != 0 || esb != 0) exp_fwd_cnt++;
        last_stall = e_stall;
        #1;
        chk("fwd_a_sel", fwd_a_sel, esa);
        chk("fwd_b_sel", fwd_b_sel, esb);
`ifdef HAZARD_STATS_EN
        chk("stall_cnt", stall_cnt, exp_stall_cnt);
        chk("fwd_cnt", fwd_cnt, exp_fwd_cnt);
`endif
    endtask

    task automatic clear_model();
        hist.delete();
        last_stall    = 1'b0;
        exp_stall_cnt = 0;
        exp_fwd_cnt   = 0;
    endtask

    task automatic nop();
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_regwrite = 0; id_memread = 0; flush = 0;
        clear_model();
        #1;
        chk("rst_sel_a", fwd_a_sel, 2'b00);
        chk("rst_sel_b", fwd_b_sel, 2'b00);
        chk("rst_stall", stall, 1'b0);
        chk("rst_pc_write", pc_write, 1'b1);
        chk("rst_ifid_write", ifid_write, 1'b1);
        chk("rst_bubble", idex_bubble, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back ALU dependency on rs
        step(1, 5'd1, 5'd2, 5'd3, 1, 0, 0);
        step(1, 5'd3, 5'd7, 5'd8, 1, 0, 0);
        chk("t1_sel_a", fwd_a_sel, 2'b10);

        // Distance-2 dependency on rt, then MEM-vs-WB priority
        step(1, 5'd1, 5'd2, 5'd4, 1, 0, 0);
        nop();
        step(1, 5'd9, 5'd4, 5'd10, 1, 0, 0);
        chk("t2_sel_b_wb", fwd_b_sel, 2'b01);
        step(1, 5'd1, 5'd2, 5'd4, 1, 0, 0);
        step(1, 5'd1, 5'd2, 5'd4, 1, 0, 0);
        step(1, 5'd9, 5'd4, 5'd11, 1, 0, 0);
        chk("t2_sel_b_prio", fwd_b_sel, 2'b10);

        // Load-use: one stall, then both operands from MEM/WB
        step(1, 5'd1, 5'd2, 5'd5, 1, 1, 0);
        step(1, 5'd5, 5'd5, 5'd6, 1, 0, 0);
        chk("t3_stalled", {31'd0, last_stall}, 32'd1);
        step(1, 5'd5, 5'd5, 5'd6, 1, 0, 0);
        chk("t3_sel_a", fwd_a_sel, 2'b01);
        chk("t3_sel_b", fwd_b_sel, 2'b01);

        // Load into r0 never stalls or forwards
        step(1, 5'd1, 5'd2, 5'd0, 1, 1, 0);
        step(1, 5'd0, 5'd0, 5'd12, 1, 0, 0);
        chk("t4_sel_a", fwd_a_sel, 2'b00);

        // Flush beats a pending load-use stall
        step(1, 5'd1, 5'd2, 5'd5, 1, 1, 0);
        step(1, 5'd5, 5'd1, 5'd6, 1, 0, 1);
        chk("t5_sel_a", fwd_a_sel, 2'b00);

        // Asynchronous reset in the middle of a stall cycle
        step(1, 5'd2, 5'd2, 5'd1, 1, 0, 0);
        step(1, 5'd1, 5'd2, 5'd5, 1, 1, 0);
        @(negedge clk);
        id_valid = 1; id_rs = 5'd5; id_rt = 5'd2; id_rd = 5'd6;
        id_regwrite = 1; id_memread = 0; flush = 0;
        #1;
        chk("t6_pre_stall", stall, 1'b1);
        chk("t6_pre_sel_a", fwd_a_sel, 2'b10);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_stall", stall, 1'b0);
        chk("t6_rst_pc_write", pc_write, 1'b1);
        chk("t6_rst_bubble", idex_bubble, 1'b0);
        chk("t6_rst_sel_a", fwd_a_sel, 2'b00);
        chk("t6_rst_sel_b", fwd_b_sel, 2'b00);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 5'd5, 5'd2, 5'd6, 1, 0, 0);
        chk("t6_clean_sel_a", fwd_a_sel, 2'b00);
`ifdef HAZARD_STATS_EN
        step(1, 5'd1, 5'd2, 5'd5, 1, 1, 0);
        step(1, 5'd5, 5'd5, 5'd6, 1, 0, 0);
        step(1, 5'd5, 5'd5, 5'd6, 1, 0, 0);
        chk("t6_stall_cnt", stall_cnt, 32'd1);
`endif

        // Random traffic over a small register set to force collisions
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                r_v  = ($urandom_range(0, 9) != 0);
                r_rs = 5'($urandom_range(0, 3));
                r_rt = 5'($urandom_range(0, 3));
                r_rd = 5'($urandom_range(0, 3));
                r_rw = ($urandom_range(0, 4) != 0);
                r_mr = ($urandom_range(0, 2) == 0);
            end
            r_fl = ($urandom_range(0, 9) == 0);
            step(r_v, r_rs, r_rt, r_rd, r_rw, r_mr, r_fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
